// File: rtl/riscv_boot_pkg.sv
// Shared constants and state type for the RISC-V boot loader.
// Frame: two length bytes, 4*N payload bytes, one XOR checksum byte.
package riscv_boot_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_LEN_LO = S_LEN_LO,
        ST_LEN_HI = S_LEN_HI,
        ST_DATA   = S_DATA,
        ST_CSUM   = S_CSUM,
        ST_DONE   = S_DONE,
        ST_ERROR  = S_ERROR
    } boot_state_t;

    localparam int         HDR_BYTES  = 2;
    localparam int         WORD_BYTES = 4;
    localparam logic [7:0] CSUM_INIT  = 8'h00;

endpackage

// File: rtl/riscv_boot_loader_word_assembler.sv
// Collects payload bytes little-endian into 32-bit words; word_valid is a
// registered one-cycle pulse carrying the completed word in word_data.
module boot_word_assembler
    import riscv_boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_index,
    output logic        word_valid,
    output logic [31:0] word_data
);

    // Holds the first three bytes of the word, byte0 ending up in bits 7:0.
    logic [23:0] partial;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_index <= 2'd0;
            partial    <= 24'd0;
            word_valid <= 1'b0;
            word_data  <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_index <= 2'd0;
                partial    <= 24'd0;
            end else if (byte_valid) begin
                partial    <= {byte_data, partial[23:8]};
                byte_index <= byte_index + 2'd1;
                if (byte_index == 2'(WORD_BYTES - 1)) begin
                    word_valid <= 1'b1;
                    word_data  <= {byte_data, partial};
                end
            end
        end
    end

endmodule

// File: rtl/riscv_boot_loader.sv
// Boot loader: receives a framed program image byte stream, writes words into
// instruction memory and releases the core only after a verified checksum.
module riscv_boot_loader
    import riscv_boot_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output boot_state_t           fsm_state
);

    localparam int MAX_WORDS = 1 << ADDR_WIDTH;

    boot_state_t         state;
    boot_state_t         state_next;
    logic [7:0]          len_lo;
    logic [7:0]          csum;
    logic [ADDR_WIDTH:0] word_target;
    logic [15:0]         len_value;
    logic [1:0]          byte_index;
    logic                accept;
    logic                start_load;
    logic                word_write;
    logic                len_over;
    logic                len_zero;
    logic                len_fail;
    logic                last_word;
    logic                csum_pass;
    logic                csum_fail;

    // Handshake: a byte moves only in a cycle where rx_valid and rx_ready are
    // both high; rx_ready depends on state alone, never on rx_valid.
    assign accept    = rx_valid && rx_ready;
    assign len_value = {rx_data, len_lo};
    assign len_over  = {16'd0, len_value} > 32'(MAX_WORDS);
    assign len_zero  = (len_value == 16'd0);
    assign last_word = ((words_loaded + (ADDR_WIDTH+1)'(1)) == word_target);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        busy       = 1'b0;
        start_load = 1'b0;
        word_write = 1'b0;
        len_fail   = 1'b0;
        csum_pass  = 1'b0;
        csum_fail  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_LEN_LO;
                    start_load = 1'b1;
                end
            end
            ST_LEN_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    if (len_over) begin
                        state_next = ST_ERROR;
                        len_fail   = 1'b1;
                    end else if (len_zero) begin
                        state_next = ST_CSUM;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid && byte_index == 2'(WORD_BYTES - 1)) begin
                    word_write = 1'b1;
                    if (last_word) state_next = ST_CSUM;
                end
            end
            ST_CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    if (rx_data == csum) begin
                        state_next = ST_DONE;
                        csum_pass  = 1'b1;
                    end else begin
                        state_next = ST_ERROR;
                        csum_fail  = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_lo       <= 8'd0;
            csum         <= CSUM_INIT;
            word_target  <= '0;
            words_loaded <= '0;
            imem_addr    <= '0;
            cpu_hold     <= HOLD_AT_RESET;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            if (start_load) begin
                csum         <= CSUM_INIT;
                words_loaded <= '0;
                done         <= 1'b0;
                error        <= 1'b0;
                cpu_hold     <= 1'b1;
            end
            // Every frame byte before the checksum byte folds into the XOR.
            if (accept && state != ST_CSUM) csum <= csum ^ rx_data;
            if (accept && state == ST_LEN_LO) len_lo <= rx_data;
            if (accept && state == ST_LEN_HI) word_target <= len_value[ADDR_WIDTH:0];
            if (word_write) begin
                imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
            end
            if (len_fail || csum_fail) error <= 1'b1;
            if (csum_pass) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
        end
    end

    boot_word_assembler u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_load),
        .byte_valid (accept && state == ST_DATA),
        .byte_data  (rx_data),
        .byte_index (byte_index),
        .word_valid (imem_we),
        .word_data  (imem_wdata)
    );

endmodule

// File: tb/tb_riscv_boot_loader.sv
// Self-checking bench for riscv_boot_loader: directed frame table, random
// frames with gaps and stray start pulses, and an asynchronous reset mid-load.
module tb_riscv_boot_loader;
    import riscv_boot_pkg::*;

    localparam int AW   = 2;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;
    logic [2:0]    fsm_state;

    riscv_boot_loader #(.ADDR_WIDTH(AW), .HOLD_AT_RESET(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected memory writes {addr, data}, in order.
    logic [AW+31:0] exp_q[$];
    logic [7:0]     frame_q[$];

    typedef struct {
        int          len;
        logic [31:0] w [MAXW];
        bit          literal;
        logic [7:0]  csum;
        bit          exp_done;
        int          exp_words;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every imem_we pulse must match the next expected write.
    always @(negedge clk) begin
        if (reset && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h, expected no write", imem_addr, imem_wdata);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                check("imem_write", {imem_addr, imem_wdata}, e);
                check("words_loaded_at_write", words_loaded, int'(e[AW+31:32]) + 1);
            end
        end
    end

    // Reference model: frame bytes and expected writes straight from the
    // frame rules. literal=1 sends csum as given; otherwise sends XOR^csum.
    task automatic build_frame(input int len, input logic [31:0] w [MAXW],
                               input bit literal, input logic [7:0] cs);
        logic [7:0] x;
        frame_q.delete();
        frame_q.push_back(len[7:0]);
        frame_q.push_back(len[15:8]);
        if (len > MAXW) return;
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < 4; b++) frame_q.push_back(w[i][8*b +: 8]);
            exp_q.push_back({AW'(i), w[i]});
        end
        x = 8'h00;
        foreach (frame_q[k]) x = x ^ frame_q[k];
        frame_q.push_back(literal ? cs : (x ^ cs));
    endtask

    task automatic set_vec(input int idx, input int len, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3, input bit literal,
                           input logic [7:0] cs, input bit exp_done, input int exp_words);
        vecs[idx].len       = len;
        vecs[idx].w[0]      = w0;
        vecs[idx].w[1]      = w1;
        vecs[idx].w[2]      = w2;
        vecs[idx].w[3]      = w3;
        vecs[idx].literal   = literal;
        vecs[idx].csum      = cs;
        vecs[idx].exp_done  = exp_done;
        vecs[idx].exp_words = exp_words;
    endtask

    // Entered and left on a negedge; rx_valid stays high on return so the
    // next byte can follow back-to-back.
    task automatic send_byte(input logic [7:0] b, input int max_gap, input bit mid_start);
        int gap;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (gap) begin
            rx_valid = 1'b0;
            start    = mid_start && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 20; t++) begin
            if (rx_ready) begin
                @(posedge clk);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL rx_ready_timeout: got rx_ready 0 for 20 cycles, expected 1");
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("hold_after_start", cpu_hold, 1);
        check("done_cleared", done, 0);
        check("error_cleared", error, 0);
        check("words_cleared", words_loaded, 0);
        check("ready_after_start", rx_ready, 1);
    endtask

    task automatic run_vector(input vec_t v, input int max_gap, input bit mid_start);
        start_load();
        build_frame(v.len, v.w, v.literal, v.csum);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i == frame_q.size() - 1 && v.len <= MAXW) begin
                check("hold_before_csum", cpu_hold, 1);
                check("done_before_csum", done, 0);
            end
            send_byte(frame_q[i], max_gap, mid_start);
        end
        rx_valid = 1'b0;
        start    = 1'b0;
        check("done", done, v.exp_done);
        check("error", error, !v.exp_done);
        check("cpu_hold", cpu_hold, !v.exp_done);
        check("busy_end", busy, 0);
        check("ready_end", rx_ready, 0);
        check("words_loaded", words_loaded, v.exp_words);
        check("pending_writes", exp_q.size(), 0);
        exp_q.delete();
        // Flags hold and nothing is accepted while finished.
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        check("done_sticky", done, v.exp_done);
        check("error_sticky", error, !v.exp_done);
        check("words_sticky", words_loaded, v.exp_words);
    endtask

    initial begin
        vec_t        r;
        logic [31:0] rw [MAXW];

        // 0x92 is the XOR of 02 00 13 00 00 00 93 00 10 00.
        set_vec(0, 2,     32'h00000013, 32'h00100093, 32'h0, 32'h0, 1, 8'h92, 1, 2);
        set_vec(1, 2,     32'h00000013, 32'h00100093, 32'h0, 32'h0, 1, 8'h00, 0, 2);
        set_vec(2, 5,     32'h0, 32'h0, 32'h0, 32'h0, 1, 8'h00, 0, 0);
        set_vec(3, 0,     32'h0, 32'h0, 32'h0, 32'h0, 1, 8'h00, 1, 0);
        set_vec(4, 4,     32'h12345678, 32'hdeadbeef, 32'h00000000, 32'hffffffff, 0, 8'h00, 1, 4);
        set_vec(5, 0,     32'h0, 32'h0, 32'h0, 32'h0, 1, 8'h55, 0, 0);
        set_vec(6, 16'h0100, 32'h0, 32'h0, 32'h0, 32'h0, 1, 8'h00, 0, 0);
        set_vec(7, 1,     32'h00000513, 32'h0, 32'h0, 32'h0, 0, 8'h01, 0, 1);

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #2 reset = 1'b0;
        #1;
        check("reset_state", fsm_state, S_IDLE);
        check("reset_hold", cpu_hold, 1);
        check("reset_ready", rx_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_we", imem_we, 0);
        check("reset_words", words_loaded, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vector(vecs[i], 0, 1'b0);

        for (int it = 0; it < 14; it++) begin
            r.len = (it == 0) ? 4 : $urandom_range(0, 5);
            for (int k = 0; k < MAXW; k++) r.w[k] = $urandom;
            r.literal   = 1'b0;
            r.csum      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            r.exp_done  = (r.len <= MAXW) && (r.csum == 8'h00);
            r.exp_words = (r.len <= MAXW) ? r.len : 0;
            run_vector(r, 3, 1'b1);
        end

        // Reset arrives while the first word's write pulse is on the bus.
        start_load();
        rw[0] = 32'hcafef00d;
        rw[1] = 32'h01020304;
        rw[2] = 32'ha5a55a5a;
        rw[3] = 32'h0;
        build_frame(3, rw, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) send_byte(frame_q[i], 0, 1'b0);
        rx_valid = 1'b0;
        #1 check("writes_before_reset", exp_q.size(), 2);
        #1 reset = 1'b0;
        #1;
        check("async_we", imem_we, 0);
        check("async_addr", imem_addr, 0);
        check("async_wdata", imem_wdata, 0);
        check("async_words", words_loaded, 0);
        check("async_busy", busy, 0);
        check("async_ready", rx_ready, 0);
        check("async_hold", cpu_hold, 1);
        check("async_done", done, 0);
        check("async_error", error, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_vector(vecs[0], 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
